// File: rtl/uart_pkg.sv
// Shared UART definitions: default line configuration, bit timing helper,
// receiver state encoding and 8N1 frame constants (also used by uart_tx).
package uart_pkg;

  localparam int CLK_FREQ_DEFAULT  = 50_000_000;
  localparam int BAUD_RATE_DEFAULT = 9600;

  localparam int   DATA_BITS  = 8;
  localparam logic STOP_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Whole clocks per bit; the remainder of the division is absorbed by
  // re-timing every frame from its own start edge.
  function automatic int bit_period(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous inputs, with a parameterised
// reset value so an idle-high line does not look like an edge out of reset.
module uart_sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge timed, mid-bit sampled, with one-cycle
// rx_valid / frame_err strobes. Define UART_RX_PARITY_EN to add a parity bit.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = CLK_FREQ_DEFAULT,
  parameter int BAUD_RATE = BAUD_RATE_DEFAULT
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] data,
  output logic       rx_valid,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       busy
);

  localparam int BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BIT_PERIOD / 2;

  localparam logic [15:0] BIT_LAST     = 16'(BIT_PERIOD - 1);
  localparam logic [15:0] HALF_LAST    = 16'(HALF_PERIOD - 1);
  localparam logic [2:0]  BIT_IDX_LAST = 3'(DATA_BITS - 1);

  if (BIT_PERIOD < 4 || BIT_PERIOD > 65535) begin : g_bad_period
    $error("uart_rx: CLK_FREQ/BAUD_RATE must give 4..65535 clocks per bit");
  end

  logic rx_s;

  uart_sync2 #(
    .WIDTH    (1),
    .RESET_VAL(1'b1)
  ) u_sync_rx (
    .clk(clk),
    .rst(rst),
    .d_i(rx),
    .q_o(rx_s)
  );

  rx_state_e   state_q;
  logic [15:0] clk_cnt_q;
  logic [2:0]  bit_idx_q;
  logic [7:0]  shift_q;
  logic [7:0]  shift_d;
  logic        rx_prev_q;
  logic [7:0]  data_q;
  logic        rx_valid_q;
  logic        frame_err_q;
  logic        busy_q;
  logic        fall_edge;

`ifdef UART_RX_PARITY_EN
  logic parity_bit_q;
  logic parity_err_q;
  logic parity_bad;

  assign parity_bad = parity_bit_q ^ (^shift_q) ^ PARITY_ODD;
`endif

  // LSB arrives first, so each new bit enters at the top and shifts down.
  assign shift_d   = {rx_s, shift_q[7:1]};
  assign fall_edge = rx_prev_q & ~rx_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      rx_prev_q    <= 1'b1;
      data_q       <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_prev_q   <= rx_s;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (fall_edge) begin
            state_q   <= START;
            clk_cnt_q <= '0;
            busy_q    <= 1'b1;
          end
        end

        // A start bit that is high again at its midpoint was only a glitch.
        START: begin
          if (clk_cnt_q == HALF_LAST) begin
            clk_cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end

        DATA: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            shift_q   <= shift_d;
            if (bit_idx_q == BIT_IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q    <= '0;
            parity_bit_q <= rx_s;
            state_q      <= STOP;
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end
`endif

        // Returning to IDLE at mid-stop-bit leaves half a bit to catch the
        // next start edge of a back-to-back frame.
        STOP: begin
          if (clk_cnt_q == BIT_LAST) begin
            clk_cnt_q <= '0;
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            if (rx_s == STOP_LEVEL) begin
              data_q     <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            parity_err_q <= parity_bad;
`endif
          end else begin
            clk_cnt_q <= clk_cnt_q + 16'd1;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign data      = data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 16 clocks per bit; parity scenarios are
// included when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int BIT_CLKS = 16;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(
    .CLK_FREQ (1600),
    .BAUD_RATE(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .data     (data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         checkCount = 0;
  int         passCount  = 0;
  int         cycleCnt   = 0;
  int         validCount = 0;
  int         errCount   = 0;
  int         bothCount  = 0;
  int         busyRise   = 0;
  int         busyFallCycle = 0;
  int         lastValidCycle = 0;
  logic       busyPrev = 1'b0;
  logic [7:0] dataQ[$];
`ifdef UART_RX_PARITY_EN
  int         parErrCount = 0;
  int         parWithValid = 0;
`endif

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Pulse monitor: outputs are sampled on the falling edge, clear of the
  // rising edge that updates them.
  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) begin
        validCount++;
        dataQ.push_back(data);
        lastValidCycle = cycleCnt;
      end
      if (frame_err) errCount++;
      if (rx_valid && frame_err) bothCount++;
`ifdef UART_RX_PARITY_EN
      if (parity_err) parErrCount++;
      if (parity_err && rx_valid) parWithValid++;
`endif
      if (busy && !busyPrev) busyRise++;
      if (!busy && busyPrev) busyFallCycle = cycleCnt;
    end
    busyPrev = busy;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic driveBit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] byteVal, input logic stopBit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(byteVal[i]);
    driveBit(stopBit);
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic applyParityFrame(input logic [7:0] byteVal, input logic parBit);
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(byteVal[i]);
    driveBit(parBit);
    driveBit(1'b1);
  endtask
`endif

  int vBase;
  int eBase;
  int startCycle;
  logic [7:0] c3Val;

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_data", 32'(data), 32'h00);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'h0);
    checkOutput("reset_frame_err", 32'(frame_err), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single good frame; latency is 9*16+8+1 from the synced edge plus 2
    // synchronizer clocks from the pin.
    vBase = validCount;
    eBase = errCount;
    startCycle = cycleCnt;
    applyStimulus(8'hA5, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("a5_data", 32'(data), 32'hA5);
    checkOutput("a5_valid_pulses", 32'(validCount - vBase), 32'd1);
    checkOutput("a5_frame_err", 32'(errCount - eBase), 32'd0);
    checkOutput("a5_latency", 32'(lastValidCycle - startCycle), 32'd155);

    // Back-to-back frames with no idle gap between stop and next start.
    dataQ.delete();
    vBase = validCount;
    eBase = errCount;
    applyStimulus(8'h00, 1'b1);
    applyStimulus(8'hFF, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("b2b_count", 32'(validCount - vBase), 32'd3);
    checkOutput("b2b_byte0", 32'(dataQ[0]), 32'h00);
    checkOutput("b2b_byte1", 32'(dataQ[1]), 32'hFF);
    checkOutput("b2b_byte2", 32'(dataQ[2]), 32'h3C);
    checkOutput("b2b_frame_err", 32'(errCount - eBase), 32'd0);

    // Bad stop bit followed by a line held low for 40 bits.
    vBase = validCount;
    eBase = errCount;
    applyStimulus(8'h55, 1'b0);
    rx = 1'b0;
    repeat (40 * BIT_CLKS) @(negedge clk);
    checkOutput("break_frame_err", 32'(errCount - eBase), 32'd1);
    checkOutput("break_no_valid", 32'(validCount - vBase), 32'd0);
    checkOutput("break_data_kept", 32'(data), 32'h3C);
    checkOutput("break_idle", 32'(busy), 32'h0);
    rx = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    applyStimulus(8'h12, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("after_break_data", 32'(data), 32'h12);
    checkOutput("after_break_valid", 32'(validCount - vBase), 32'd1);
    checkOutput("after_break_err", 32'(errCount - eBase), 32'd1);

    // Short glitch: busy falls HALF_PERIOD+1 after the synced edge, +2 from pin.
    vBase = validCount;
    eBase = errCount;
    busyRise = 0;
    startCycle = cycleCnt;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * BIT_CLKS) @(negedge clk);
    checkOutput("glitch_busy_rise", 32'(busyRise), 32'd1);
    checkOutput("glitch_busy_fall", 32'(busyFallCycle - startCycle), 32'd11);
    checkOutput("glitch_no_valid", 32'(validCount - vBase), 32'd0);
    checkOutput("glitch_no_err", 32'(errCount - eBase), 32'd0);

    // Reset in the middle of data bit 4 of 8'hC3.
    vBase = validCount;
    eBase = errCount;
    c3Val = 8'hC3;
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(c3Val[i]);
    rx = c3Val[4];
    repeat (BIT_CLKS / 2) @(negedge clk);
    checkOutput("midframe_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    rx  = 1'b1;
    #1;
    checkOutput("reset_abort_busy", 32'(busy), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3 * BIT_CLKS) @(negedge clk);
    applyStimulus(8'h81, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("post_reset_data", 32'(data), 32'h81);
    checkOutput("post_reset_valid", 32'(validCount - vBase), 32'd1);
    checkOutput("post_reset_err", 32'(errCount - eBase), 32'd0);

`ifdef UART_RX_PARITY_EN
    // Even parity: 8'h07 has three ones, so the correct parity bit is 1.
    vBase = validCount;
    parErrCount = 0;
    parWithValid = 0;
    applyParityFrame(8'h07, 1'b0);
    repeat (8) @(negedge clk);
    checkOutput("par_bad_data", 32'(data), 32'h07);
    checkOutput("par_bad_valid", 32'(validCount - vBase), 32'd1);
    checkOutput("par_bad_together", 32'(parWithValid), 32'd1);
    applyParityFrame(8'h07, 1'b1);
    repeat (8) @(negedge clk);
    checkOutput("par_good_valid", 32'(validCount - vBase), 32'd2);
    checkOutput("par_good_no_err", 32'(parErrCount), 32'd1);
`endif

    checkOutput("valid_err_exclusive", 32'(bothCount), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
